fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754-style floating-point adder with valid/ready handshake.
//  Handles both signs (true add/subtract), hidden bit from the exponent, LZC renormalisation and inf/NaN/overflow.
//  Successor to the combinational single-precision adder; sits between operand-fetch and result-writeback in the FP datapath.
// PARAMETERS
//  EXP_W   8    exponent width; bias = 2**(EXP_W-1)-1
//  MAN_W   23   stored mantissa width (hidden bit excluded); word W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   W      operand A {sign, exp, man}
//  b          in   W      operand B
//  out_valid  out  1      sum/flags valid
//  out_ready  in   1      downstream accepts result
//  sum        out  W      result
//  flags      out  3      {invalid, overflow, underflow}, qualified by out_valid
// BEHAVIOUR
//  Reset: all stage valids, out_valid, sum, flags = 0; in-flight ops discarded, none resurrected after release.
//  Handshake: transfer on valid&ready at each side. adv = !out_valid | out_ready; in_ready = adv (comb).
//   Pipeline advances as a unit on adv; bubbles are not collapsed. out_valid/sum held stable while !out_ready.
//  Latency: exactly 3 cycles accept->out_valid when not stalled; throughput 1/cycle; order preserved.
//  Decode: exp==0 -> operand is zero (subnormals flushed, sign kept); exp==all-ones: man==0 inf, else NaN.
//  S1 (align): swap so |X|>=|Y| (compare {exp,man}); d = Xexp-Yexp; Y sig {1,man} shifted right d into
//   MAN_W+4-bit field {hidden, man, G, R, S}; bits shifted past S OR into S; d >= MAN_W+3 -> Y field = S only.
//  S2 (add): signs equal -> X+Y magnitude; else X-Y (never negative). Result sign = X sign.
//   Exact zero from subtraction -> +0. (-0)+(-0) -> -0.
//  S3 (normalise/round): carry-out -> shift right 1 (sticky keeps shifted bit), exp+1;
//   else leading-zero count L, shift left L, exp-L. Then rounding (see CONFIGURATION).
//   Rounding carry into hidden+1 -> renormalise, exp+1.
//  Overflow: final exp >= all-ones -> +/-inf, overflow=1.
//  Underflow: final exp <= 0 with nonzero magnitude -> signed zero, underflow=1.
//  Specials (bypass arithmetic, still 3 cycles): any NaN -> canonical qNaN {0, all-ones, 1, 0..}, invalid=1;
//   inf + -inf -> qNaN, invalid=1; inf + finite or same-sign inf -> that inf, flags 0.
//  Zero operand: result equals other operand exactly (zero+zero sign rule above).
//  Simultaneous out_ready drop and in_valid: in_ready=0 that cycle; a/b must be held by source (no loss).
// CONFIGURATION
//  ROUND_NEAREST_EN defined: round-to-nearest-even on G,R,S (round up if G&(R|S|lsb)).
//  ROUND_NEAREST_EN undefined: truncation (round toward zero); G/R/S ignored; rounding logic omitted.
//  Overflow result identical in both modes (inf).
// TESTING  (EXP_W=8, MAN_W=23)
//  3F800000 + 3F800000 -> 40000000 exactly 3 cycles after accept, flags 000.
//  3FC00000 + BF000000 -> 3F800000; 3F800000 + BF800000 -> 00000000 (+0), flags 000.
//  7F7FFFFF + 7F7FFFFF -> 7F800000, flags 010; 7F800000 + FF800000 -> 7FC00000, flags 100.
//  3F800001 + 33800000 (tie) -> 3F800002 with ROUND_NEAREST_EN, 3F800001 without.
//  Stream 6 ops back-to-back, out_ready=0 for 5 cycles mid-stream: in_ready drops, sum held, all 6 out in order.
//  Assert rst with 3 ops in flight -> out_valid=0 next cycle, no stale result after release; next op 3-cycle latency.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder with valid/ready handshake.
//   Stage 1 decodes specials, swaps so |X| >= |Y| and aligns Y with guard/round/sticky bits.
//   Stage 2 adds or subtracts the aligned significands.
//   Stage 3 renormalises, rounds and applies overflow/underflow, then registers the result.
// Subnormal operands are flushed to zero; tiny results flush to signed zero.
// Optional feature macro: ROUND_NEAREST_EN selects round-to-nearest-even; without it the
// result is truncated toward zero.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready = !out_valid | out_ready
//   a, b                operands {sign, exp, man}
//   out_valid, out_ready result handshake; sum/flags held while stalled
//   sum                 result word
//   flags               {invalid, overflow, underflow}
module fp_add_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum,
    output logic [2:0]           flags
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned FW  = MAN_W + 4;      // {hidden, man, G, R, S}
    localparam int unsigned EW  = EXP_W + 2;      // two's-complement working exponent
    localparam int unsigned LZW = $clog2(FW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             valid;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [2:0]       spec_flags;
        logic             sign;
        logic             sub;
        logic [EXP_W-1:0] exp;
        logic [FW-1:0]    xf;
        logic [FW-1:0]    yf;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [2:0]       spec_flags;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FW:0]      mag;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] sum_q, sum_d;
    logic [2:0]   flags_q, flags_d;

    // The whole pipeline moves together; bubbles are not collapsed.
    logic adv;
    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv;

    // Stage 1: decode, swap, align
    logic             a_s, b_s, x_s, y_s;
    logic [EXP_W-1:0] a_e, b_e, x_e, y_e, diff;
    logic [MAN_W-1:0] a_m, b_m, x_m, y_m;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [2*FW-1:0]  y_full;

    assign {a_s, a_e, a_m} = a;
    assign {b_s, b_e, b_m} = b;

    always_comb begin
        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_inf  = (a_e == EXP_ONES) && (a_m == '0);
        b_inf  = (b_e == EXP_ONES) && (b_m == '0);
        a_nan  = (a_e == EXP_ONES) && (a_m != '0);
        b_nan  = (b_e == EXP_ONES) && (b_m != '0);
        swap   = {b_e, b_m} > {a_e, a_m};
        {x_s, x_e, x_m} = swap ? b : a;
        {y_s, y_e, y_m} = swap ? a : b;
        diff   = x_e - y_e;
        // Lower half of the wide shift collects every bit pushed past S.
        y_full = {1'b1, y_m, 3'b000, {FW{1'b0}}} >> diff;

        s1_d = s1_q;
        if (adv) begin
            s1_d.valid      = in_valid;
            s1_d.spec       = 1'b1;
            s1_d.spec_res   = '0;
            s1_d.spec_flags = 3'b000;
            if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
                s1_d.spec_res   = QNAN;
                s1_d.spec_flags = 3'b100;
            end else if (a_inf) begin
                s1_d.spec_res = a;
            end else if (b_inf) begin
                s1_d.spec_res = b;
            end else if (a_zero && b_zero) begin
                s1_d.spec_res = {a_s & b_s, {(W-1){1'b0}}};
            end else if (a_zero) begin
                s1_d.spec_res = b;
            end else if (b_zero) begin
                s1_d.spec_res = a;
            end else begin
                s1_d.spec = 1'b0;
            end
            s1_d.sign = x_s;
            s1_d.sub  = x_s ^ y_s;
            s1_d.exp  = x_e;
            s1_d.xf   = {1'b1, x_m, 3'b000};
            if (32'(diff) >= FW - 1) begin
                s1_d.yf = {{(FW-1){1'b0}}, 1'b1};
            end else begin
                s1_d.yf = y_full[2*FW-1:FW] | {{(FW-1){1'b0}}, |y_full[FW-1:0]};
            end
        end
    end

    // Stage 2: magnitude add/subtract; X >= Y so the difference is never negative
    always_comb begin
        s2_d = s2_q;
        if (adv) begin
            s2_d.valid      = s1_q.valid;
            s2_d.spec       = s1_q.spec;
            s2_d.spec_res   = s1_q.spec_res;
            s2_d.spec_flags = s1_q.spec_flags;
            s2_d.exp        = s1_q.exp;
            s2_d.mag        = s1_q.sub ? ({1'b0, s1_q.xf} - {1'b0, s1_q.yf})
                                       : ({1'b0, s1_q.xf} + {1'b0, s1_q.yf});
            // Exact cancellation yields +0.
            s2_d.sign       = (s2_d.mag == '0) ? 1'b0 : s1_q.sign;
        end
    end

    // Stage 3: normalise, round, range check
    logic [LZW-1:0]  lz;
    logic [FW-1:0]   nf;
    logic [EW-1:0]   ne, fe;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] fm;
    logic            ovf, unf;

    always_comb begin
        lz = LZW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (s2_q.mag[i]) lz = LZW'(int'(FW) - 1 - i);
        end
        if (s2_q.mag[FW]) begin
            nf = {s2_q.mag[FW:2], |s2_q.mag[1:0]};
            ne = {2'b00, s2_q.exp} + EW'(1);
        end else begin
            nf = s2_q.mag[FW-1:0] << lz;
            ne = {2'b00, s2_q.exp} - EW'(lz);
        end
    end

`ifdef ROUND_NEAREST_EN
    logic rnd_up;
    always_comb begin
        rnd_up = nf[2] & (nf[1] | nf[0] | nf[3]);
        mr     = {1'b0, nf[FW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    end
`else
    logic unused_grs;
    assign unused_grs = ^nf[2:0];
    assign mr         = {1'b0, nf[FW-1:3]};
`endif

    always_comb begin
        // Rounding carried past the hidden bit: significand is now exactly 2.0.
        if (mr[MAN_W+1]) begin
            fe = ne + EW'(1);
            fm = mr[MAN_W:1];
        end else begin
            fe = ne;
            fm = mr[MAN_W-1:0];
        end
        ovf = !fe[EW-1] && (fe >= {2'b00, EXP_ONES});
        unf = fe[EW-1] || (fe == '0);

        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        flags_d     = flags_q;
        if (adv) begin
            out_valid_d = s2_q.valid;
            if (s2_q.spec) begin
                sum_d   = s2_q.spec_res;
                flags_d = s2_q.spec_flags;
            end else if (s2_q.mag == '0) begin
                sum_d   = '0;
                flags_d = 3'b000;
            end else if (ovf) begin
                sum_d   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
                flags_d = 3'b010;
            end else if (unf) begin
                sum_d   = {s2_q.sign, {(W-1){1'b0}}};
                flags_d = 3'b001;
            end else begin
                sum_d   = {s2_q.sign, fe[EXP_W-1:0], fm};
                flags_d = 3'b000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe (EXP_W=8, MAN_W=23): directed vector table, stall and reset sequences,
// and randomized traffic scored against an exact big-integer reference model.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic [2:0]  flags;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] QNAN = 32'h7FC00000;
`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] TIE_RES = 32'h3F800002;
`else
    localparam logic [31:0] TIE_RES = 32'h3F800001;
`endif

    typedef struct { logic [31:0] sum; logic [2:0] flags; int cyc; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] sum; logic [2:0] flags; } vec_t;

    exp_t        sb[$];
    int          total = 0, bad = 0, cyc = 0, n_out = 0, n_block = 0, last_lat = 0;
    bit          lat_chk = 0, rdone = 0;
    logic [31:0] last_sum;
    logic [2:0]  last_flags;

    // Exact reference: operands become integers scaled by 2^(exp-1), summed exactly, then
    // rounded to 24 significant bits and range-checked.
    function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic         sx, sy, s, rup;
        int           ex, ey, p, k, e;
        logic [22:0]  mx, my;
        logic [299:0] ix, iy, m, q, rem, half;
        sx = x[31]; ex = int'(x[30:23]); mx = x[22:0];
        sy = y[31]; ey = int'(y[30:23]); my = y[22:0];
        if ((ex == 255 && mx != 0) || (ey == 255 && my != 0)) return {3'b100, QNAN};
        if (ex == 255 && ey == 255) return (sx != sy) ? {3'b100, QNAN} : {3'b000, x};
        if (ex == 255) return {3'b000, x};
        if (ey == 255) return {3'b000, y};
        if (ex == 0 && ey == 0) return {3'b000, sx & sy, 31'd0};
        if (ex == 0) return {3'b000, y};
        if (ey == 0) return {3'b000, x};
        ix = 300'({1'b1, mx}) << (ex - 1);
        iy = 300'({1'b1, my}) << (ey - 1);
        if (sx == sy) begin m = ix + iy; s = sx; end
        else if (ix >= iy) begin m = ix - iy; s = sx; end
        else begin m = iy - ix; s = sy; end
        if (m == 0) return 35'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        e = p + 1 - 23;
        if (p > 23) begin
            k    = p - 23;
            q    = m >> k;
            rem  = m & ((300'd1 << k) - 300'd1);
            half = 300'd1 << (k - 1);
            rup  = (rem > half) || (rem == half && q[0]);
`ifndef ROUND_NEAREST_EN
            rup  = 1'b0;
`endif
            if (rup) q = q + 300'd1;
        end else begin
            q = m << (23 - p);
        end
        if (q[24]) begin q = q >> 1; e++; end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, s, 31'd0};
        return {3'b000, s, 8'(e), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        int   n = 0;
        logic acc = 1'b0;
        a = x; b = y; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL drive_timeout: accepted %0d want 1", acc);
        end
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (n_out < target && n < 60) begin @(posedge clk); #1; n++; end
        check("output_count", 32'(n_out), 32'(target));
    endtask

    task automatic gen(output logic [31:0] x, output logic [31:0] y);
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        case ($urandom_range(0, 7))
            0:       ea = 8'hFF;
            1:       ea = 8'h00;
            2:       ea = 8'($urandom_range(1, 3));
            3:       ea = 8'hFE;
            default: ea = 8'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 5))
            0:       eb = 8'($urandom_range(0, 255));
            1:       eb = ea - 8'($urandom_range(20, 30));
            default: eb = ea + 8'($urandom_range(0, 4)) - 8'd2;
        endcase
        ma = 23'($urandom);
        mb = 23'($urandom);
        if ($urandom_range(0, 5) == 0) mb = 23'd0;
        if ($urandom_range(0, 9) == 0) ma = '1;
        x = {1'($urandom), ea, ma};
        y = {1'($urandom), eb, mb};
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scores every output transfer against the model and checks stall stability.
    initial begin : mon
        exp_t        e;
        logic [31:0] es, hold_sum;
        logic [2:0]  ef, hold_flags;
        bit          hold_chk;
        hold_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 0;
            end else begin
                if (hold_chk) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_sum", sum, hold_sum);
                    check("hold_flags", 32'(flags), 32'(hold_flags));
                end
                hold_chk = out_valid && !out_ready;
                hold_sum = sum;
                hold_flags = flags;
                if (in_valid && !in_ready) n_block++;
                if (in_valid && in_ready) begin
                    {ef, es} = ref_add(a, b);
                    sb.push_back('{sum: es, flags: ef, cyc: cyc});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("model_sum", sum, e.sum);
                        check("model_flags", 32'(flags), 32'(e.flags));
                        last_sum = sum;
                        last_flags = flags;
                        last_lat = cyc - e.cyc;
                        if (lat_chk) check("latency", 32'(last_lat), 32'd3);
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        vec_t        tbl[16];
        logic [31:0] x, y;
        int          prev, nb;
        bit          stale;

        tbl[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000};
        tbl[1]  = '{32'h3FC00000, 32'hBF000000, 32'h3F800000, 3'b000};
        tbl[2]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000};
        tbl[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010};
        tbl[4]  = '{32'h7F800000, 32'hFF800000, QNAN,         3'b100};
        tbl[5]  = '{32'h3F800001, 32'h33800000, TIE_RES,      3'b000};
        tbl[6]  = '{32'h00000000, 32'h3F800000, 32'h3F800000, 3'b000};
        tbl[7]  = '{32'h80000000, 32'h80000000, 32'h80000000, 3'b000};
        tbl[8]  = '{32'h80000000, 32'h00000000, 32'h00000000, 3'b000};
        tbl[9]  = '{32'h7F800001, 32'h3F800000, QNAN,         3'b100};
        tbl[10] = '{32'h7F800000, 32'hBF800000, 32'h7F800000, 3'b000};
        tbl[11] = '{32'h00C00000, 32'h80800000, 32'h00000000, 3'b001};
        tbl[12] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 3'b000};
        tbl[13] = '{32'hC0400000, 32'h3F800000, 32'hC0000000, 3'b000};
        tbl[14] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 3'b010};
        tbl[15] = '{32'h3F800000, 32'h80000000, 32'h3F800000, 3'b000};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors, one at a time, with exact latency
        lat_chk = 1;
        for (int i = 0; i < 16; i++) begin
            prev = n_out;
            drive(tbl[i].a, tbl[i].b);
            in_valid = 1'b0;
            wait_out(prev + 1);
            check($sformatf("vec%0d_sum", i), last_sum, tbl[i].sum);
            check($sformatf("vec%0d_flags", i), 32'(last_flags), 32'(tbl[i].flags));
        end

        // Six back-to-back ops with a 5-cycle downstream stall in the middle
        lat_chk = 0;
        prev = n_out;
        nb = n_block;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    gen(x, y);
                    drive(x, y);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_out(prev + 6);
        check("in_ready_dropped", 32'(n_block > nb), 32'd1);
        check("stall_queue_empty", 32'(sb.size()), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            gen(x, y);
            drive(x, y);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        prev = n_out;
        @(negedge clk);
        check("inflight_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        check("no_stale_after_rst", 32'(stale), 32'd0);
        check("no_outputs_after_rst", 32'(n_out), 32'(prev));
        @(posedge clk); #1;
        lat_chk = 1;
        drive(32'h3F800000, 32'h3F800000);
        in_valid = 1'b0;
        wait_out(prev + 1);
        check("post_rst_sum", last_sum, 32'h40000000);

        // Random traffic with random back-pressure
        lat_chk = 0;
        prev = n_out;
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    gen(x, y);
                    drive(x, y);
                end
                in_valid = 1'b0;
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_out(prev + 300);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
